// File: rtl/sram_rd_streamer.sv
// -----------------------------------------------------------------------------
// sram_rd_streamer
//   Read-side master for one port of the on-chip dual-port SRAM buffer. A burst
//   command (start address, beats-1) is turned into sequential reads on the
//   SRAM's registered 1-cycle-latency read port. The returned words are
//   presented as a valid/ready stream with last-beat marking.
//
//   Handshake semantics (both cmd_* and m_*): a transfer happens on a rising
//   clock edge where valid and ready are both 1. A producer holding valid=1
//   keeps its payload stable until that edge; ready may depend on state only.
//
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     cmd_valid/ready command handshake; cmd_addr first word, cmd_len beats-1
//     sram_en/addr    SRAM read request (combinational from state registers)
//     sram_rdata      SRAM read data, valid the cycle after sram_en
//     m_valid/ready   output stream handshake; m_data payload, m_last end mark
//     busy            burst in progress (ISSUE or DRAIN)
//     done            one-cycle pulse after the last beat is accepted
//     dbg_state       current FSM state encoding (0 IDLE, 1 ISSUE, 2 DRAIN)
// -----------------------------------------------------------------------------
module sram_rd_streamer #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  sram_en,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  localparam int CW = LEN_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         len_q;
  logic [CW-1:0]         issued_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic                  buf_last_q [2];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;
  logic                  done_q;

  logic                  pop;
  logic                  issue;
  logic                  issue_last;
  logic [ADDR_WIDTH-1:0] addr_next;

  assign m_valid   = (count_q != 2'd0);
  assign m_data    = buf_data_q[rd_ptr_q];
  assign m_last    = buf_last_q[rd_ptr_q];
  assign pop       = m_valid && m_ready;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

  // Issue only when the word would still fit after this cycle's pop:
  // count + inflight - pop < 2, rearranged to avoid an unsigned underflow.
  assign issue      = (state_q == S_ISSUE) &&
                      (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  assign issue_last = (issued_q == len_q);
  assign sram_en    = issue;
  assign sram_addr  = addr_q;

  // Explicit wrap so non-power-of-two depths stay inside the array.
  assign addr_next = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      buf_data_q[0]   <= '0;
      buf_data_q[1]   <= '0;
      buf_last_q[0]   <= 1'b0;
      buf_last_q[1]   <= 1'b0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      done_q          <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= issue && issue_last;

      // A read issued last cycle lands in the buffer now.
      if (inflight_q) begin
        buf_data_q[wr_ptr_q] <= sram_rdata;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};

      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q   <= cmd_addr;
            len_q    <= {1'b0, cmd_len};
            issued_q <= '0;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue) begin
            addr_q   <= addr_next;
            issued_q <= issued_q + 1'b1;
            if (issue_last) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (pop && m_last) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rd_streamer.sv
// -----------------------------------------------------------------------------
// tb_sram_rd_streamer
//   Bench for sram_rd_streamer: behavioural SRAM, per-burst expected address and
//   beat queues built from the command, a negedge monitor scoring every accepted
//   beat and every read request, plus cycle-exact checks for directed cases.
// -----------------------------------------------------------------------------
module tb_sram_rd_streamer;

  localparam int DW    = 128;
  localparam int DEPTH = 2048;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = 12;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          sram_en;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_rdata;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  sram_rd_streamer #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .sram_en(sram_en), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (sram_en) sram_rdata <= mem[sram_addr];
  end

  // ---------------- scoreboard state ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [DW:0]   exp_q[$];       // {last, data}
  logic [AW-1:0] exp_addr_q[$];
  int            iss_cnt, acc_cnt;
  logic          done_pending;
  logic          prev_stall;
  logic [DW:0]   prev_beat;

  task automatic check_eq(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- m_ready driver ----------------
  logic rand_ready;
  logic ready_fix;
  int   ready_pct;
  always @(posedge clk) begin
    #1;
    if (rand_ready) m_ready = ($urandom_range(0, 99) < ready_pct);
    else            m_ready = ready_fix;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_addr_q.delete();
      iss_cnt      = 0;
      acc_cnt      = 0;
      done_pending = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      logic [DW:0] e;
      check_eq("done_timing", {{DW{1'b0}}, done}, {{DW{1'b0}}, done_pending});
      done_pending = 1'b0;
      if (prev_stall) begin
        check_eq("stall_valid", {{DW{1'b0}}, m_valid}, 1);
        check_eq("stall_beat", {m_last, m_data}, prev_beat);
      end
      if (sram_en) begin
        iss_cnt++;
        if (exp_addr_q.size() == 0) check_eq("unexpected_read", 1, 0);
        else check_eq("read_addr", {{(DW+1-AW){1'b0}}, sram_addr},
                      {{(DW+1-AW){1'b0}}, exp_addr_q.pop_front()});
      end
      if (m_valid && m_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) check_eq("unexpected_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("beat", {m_last, m_data}, e);
          done_pending = e[DW];
        end
      end
      check_eq("outstanding_le2", {{DW{1'b0}}, ((iss_cnt - acc_cnt) <= 2)}, 1);
      prev_stall = m_valid && !m_ready;
      prev_beat  = {m_last, m_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [AW-1:0] a, input logic [LW-1:0] l);
    for (int i = 0; i <= int'(l); i++) begin
      int wa;
      wa = (int'(a) + i) % DEPTH;
      exp_addr_q.push_back(AW'(wa));
      exp_q.push_back({(i == int'(l)), mem[wa]});
    end
  endtask

  // Call just after a posedge; returns one cycle after the handshake (T+1).
  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
    logic ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check_eq("cmd_accept", {{DW{1'b0}}, ok}, 1);
    push_exp(a, l);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    check_eq("done_seen", {{DW{1'b0}}, got}, 1);
    check_eq("queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals();
    check_eq("rst_cmd_ready", {{DW{1'b0}}, cmd_ready}, 1);
    check_eq("rst_sram_en",   {{DW{1'b0}}, sram_en}, 0);
    check_eq("rst_sram_addr", {{(DW+1-AW){1'b0}}, sram_addr}, 0);
    check_eq("rst_m_valid",   {{DW{1'b0}}, m_valid}, 0);
    check_eq("rst_m_data",    {1'b0, m_data}, 0);
    check_eq("rst_m_last",    {{DW{1'b0}}, m_last}, 0);
    check_eq("rst_busy",      {{DW{1'b0}}, busy}, 0);
    check_eq("rst_done",      {{DW{1'b0}}, done}, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [AW-1:0] ra;
    logic [LW-1:0] rl;
    logic          ok;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    rand_ready = 1'b0; ready_fix = 1'b1; ready_pct = 60; m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;

    // Single beat: exact latency.
    mem[16] = {4{32'hA5A5_0010}};
    send_cmd(AW'(16), '0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_eq("sb_sram_en", {{DW{1'b0}}, sram_en}, (k == 1));
      check_eq("sb_m_valid", {{DW{1'b0}}, m_valid}, (k == 3));
      check_eq("sb_m_last",  {{DW{1'b0}}, m_last},  (k == 3));
      check_eq("sb_done",    {{DW{1'b0}}, done},    (k == 4));
      check_eq("sb_busy",    {{DW{1'b0}}, busy},    (k <= 3));
      check_eq("sb_cmd_rdy", {{DW{1'b0}}, cmd_ready}, (k == 4));
    end
    check_eq("sb_empty", exp_q.size(), 0);
    @(posedge clk); #1;

    // Streaming: 8 beats, no bubbles.
    for (int i = 0; i < 8; i++) mem[256 + i] = DW'(256 + i);
    send_cmd(AW'(256), LW'(7));
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check_eq("st_sram_en", {{DW{1'b0}}, sram_en}, (k >= 1 && k <= 8));
      check_eq("st_m_valid", {{DW{1'b0}}, m_valid}, (k >= 3 && k <= 10));
      check_eq("st_m_last",  {{DW{1'b0}}, m_last},  (k == 10));
      check_eq("st_done",    {{DW{1'b0}}, done},    (k == 11));
      check_eq("st_busy",    {{DW{1'b0}}, busy},    (k <= 10));
    end
    check_eq("st_empty", exp_q.size(), 0);
    @(posedge clk); #1;

    // Backpressure with random stalls.
    rand_ready = 1'b1; ready_pct = 40;
    send_cmd(AW'(256), LW'(7));
    wait_done();

    // Address wrap.
    ready_pct = 70;
    send_cmd(AW'(DEPTH - 2), LW'(3));
    wait_done();

    // Back-to-back: second command held valid during the first burst.
    send_cmd(AW'(500), LW'(5));
    cmd_valid = 1'b1; cmd_addr = AW'(900); cmd_len = LW'(4);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    check_eq("b2b_accept", {{DW{1'b0}}, ok}, 1);
    check_eq("b2b_with_done", {{DW{1'b0}}, done}, 1);
    check_eq("b2b_first_drained", exp_q.size() + exp_addr_q.size(), 0);
    push_exp(AW'(900), LW'(4));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done();

    // Random bursts.
    for (int n = 0; n < 8; n++) begin
      ra = AW'($urandom_range(0, DEPTH - 1));
      rl = LW'($urandom_range(0, 20));
      ready_pct = $urandom_range(30, 100);
      send_cmd(ra, rl);
      wait_done();
    end

    // Reset mid-burst after 3 accepted beats.
    rand_ready = 1'b0; ready_fix = 1'b1;
    @(posedge clk); #1;
    send_cmd(AW'(512), LW'(7));
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (acc_cnt >= 3) begin ok = 1'b1; break; end
    end
    check_eq("mid_three_beats", {{DW{1'b0}}, ok}, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("abort_no_done",  {{DW{1'b0}}, done}, 0);
      check_eq("abort_no_valid", {{DW{1'b0}}, m_valid}, 0);
      check_eq("abort_no_read",  {{DW{1'b0}}, sram_en}, 0);
    end
    @(posedge clk); #1;
    send_cmd(AW'(1000), LW'(9));
    wait_done();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
